// File: rtl/hazard_pkg.sv
// hazard_pkg: types and constants shared by the hazard scoreboard files.
//   state_t  : scoreboard FSM states (also visible on the debug state output)
//   FWD_*    : EXEC operand mux select encodings
package hazard_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_MC_BUSY    = 2'd2
  } state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;  // operand from register file
  localparam logic [1:0] FWD_WB  = 2'b01;  // operand from WB stage result
  localparam logic [1:0] FWD_MEM = 2'b10;  // operand from MEM stage result

endpackage

// File: rtl/hazard_fwd.sv
// hazard_fwd: combinational forwarding select for one EXEC source operand.
// Ports:
//   exec_rs_i          EXEC source register address
//   mem_rd_i/mem_we_i  MEM stage destination and write enable
//   wb_rd_i/wb_we_i    WB stage destination and write enable
//   fwd_o              operand mux select (FWD_RF / FWD_WB / FWD_MEM)
// The MEM stage holds the younger result, so it wins over WB. x0 never forwards.
module hazard_fwd
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] exec_rs_i,
  input  logic [REG_AW-1:0] mem_rd_i,
  input  logic              mem_we_i,
  input  logic [REG_AW-1:0] wb_rd_i,
  input  logic              wb_we_i,
  output logic [1:0]        fwd_o
);

  logic mem_hit;
  logic wb_hit;

  assign mem_hit = mem_we_i && (mem_rd_i != '0) && (mem_rd_i == exec_rs_i);
  assign wb_hit  = wb_we_i  && (wb_rd_i  != '0) && (wb_rd_i  == exec_rs_i);

  always_comb begin
    fwd_o = FWD_RF;
    if (mem_hit) begin
      fwd_o = FWD_MEM;
    end else if (wb_hit) begin
      fwd_o = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: pipeline hazard unit with operand forwarding, branch/jump
// flush, a LOAD_LAT-cycle load-use stall and a multi-cycle unit interlock with
// a timeout watchdog.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   FETCH_valid/rs1/rs2          decode-stage instruction and sources
//   EXEC_valid/rs1/rs2/rd        EXEC-stage instruction, sources, destination
//   EXEC_mem2reg                 EXEC instruction is a load
//   EXEC_mc_start                EXEC instruction uses the multi-cycle unit
//   mc_done                      multi-cycle result valid pulse
//   MEM_valid/MEM_rd/WB_rd       later-stage valid and destinations
//   MEM_rd_reg_write/WB_rd_reg_write  destination write enables
//   BRA, JMP                     taken branch / jump resolved in MEM
//   FWD_rs1, FWD_rs2             EXEC operand mux selects
//   FETCH_stall, EXEC_stall      hold IF/ID, ID/EX registers
//   EXEC_flush, MEM_flush        bubble into ID/EX, EX/MEM at next edge
//   mc_kill                      abort the multi-cycle unit
//   mc_timeout                   sticky watchdog error
//   dbg_state_o                  current FSM state (debug)
// Optional: define HAZARD_STATS_EN to add the saturating statistics outputs
//   stat_stall_cycles, stat_flushes, stat_mc_ops (STAT_W bits each).
// All outputs are Mealy (state plus current inputs) and are forced to 0 while rst=1.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int LOAD_LAT   = 1,
  parameter int MC_MAX_LAT = 40
`ifdef HAZARD_STATS_EN
  ,
  parameter int STAT_W     = 32
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              FETCH_valid,
  input  logic [REG_AW-1:0] FETCH_rs1,
  input  logic [REG_AW-1:0] FETCH_rs2,
  input  logic              EXEC_valid,
  input  logic [REG_AW-1:0] EXEC_rs1,
  input  logic [REG_AW-1:0] EXEC_rs2,
  input  logic [REG_AW-1:0] EXEC_rd,
  input  logic              EXEC_mem2reg,
  input  logic              EXEC_mc_start,
  input  logic              mc_done,
  input  logic              MEM_valid,
  input  logic [REG_AW-1:0] MEM_rd,
  input  logic [REG_AW-1:0] WB_rd,
  input  logic              MEM_rd_reg_write,
  input  logic              WB_rd_reg_write,
  input  logic              BRA,
  input  logic              JMP,
  output logic [1:0]        FWD_rs1,
  output logic [1:0]        FWD_rs2,
  output logic              FETCH_stall,
  output logic              EXEC_stall,
  output logic              EXEC_flush,
  output logic              MEM_flush,
  output logic              mc_kill,
  output logic              mc_timeout,
  output logic [1:0]        dbg_state_o
`ifdef HAZARD_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_stall_cycles,
  output logic [STAT_W-1:0] stat_flushes,
  output logic [STAT_W-1:0] stat_mc_ops
`endif
);

  // The counter is shared by the load stall and the MC watchdog; it is sized
  // for MC_MAX_LAT and widened only if LOAD_LAT is larger.
  localparam int CNT_MAX = (MC_MAX_LAT > LOAD_LAT) ? MC_MAX_LAT : LOAD_LAT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] MC_LIMIT = CNT_W'(MC_MAX_LAT);
  localparam logic [CNT_W-1:0] LD_INIT  = CNT_W'(LOAD_LAT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;

  logic       redirect;
  logic       load_use;
  logic       mc_req;
  logic       wd_fire;
  logic [1:0] fwd1_raw, fwd2_raw;

  // ---------------------------------------------------------------- forwarding
  hazard_fwd #(.REG_AW(REG_AW)) u_fwd_rs1 (
    .exec_rs_i (EXEC_rs1),
    .mem_rd_i  (MEM_rd),
    .mem_we_i  (MEM_rd_reg_write),
    .wb_rd_i   (WB_rd),
    .wb_we_i   (WB_rd_reg_write),
    .fwd_o     (fwd1_raw)
  );

  hazard_fwd #(.REG_AW(REG_AW)) u_fwd_rs2 (
    .exec_rs_i (EXEC_rs2),
    .mem_rd_i  (MEM_rd),
    .mem_we_i  (MEM_rd_reg_write),
    .wb_rd_i   (WB_rd),
    .wb_we_i   (WB_rd_reg_write),
    .fwd_o     (fwd2_raw)
  );

  // ------------------------------------------------------------ hazard decode
  assign redirect = MEM_valid && (BRA || JMP);
  assign load_use = FETCH_valid && EXEC_valid && EXEC_mem2reg && (EXEC_rd != '0) &&
                    ((EXEC_rd == FETCH_rs1) || (EXEC_rd == FETCH_rs2));
  assign mc_req   = EXEC_valid && EXEC_mc_start;
  // Watchdog ranks below both a redirect and a completing mc_done.
  assign wd_fire  = (state_q == ST_MC_BUSY) && !redirect && !mc_done && (cnt_q >= MC_LIMIT);

  // ------------------------------------------------------------ state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  // ---------------------------------------------------------------- next state
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    unique case (state_q)
      ST_IDLE: begin
        if (redirect) begin
          state_d = ST_IDLE;
        end else if (load_use) begin
          // The detecting cycle is the first stall cycle; LOAD_STALL covers the rest.
          if (LOAD_LAT > 1) begin
            cnt_d   = LD_INIT;
            state_d = ST_LOAD_STALL;
          end
        end else if (mc_req) begin
          cnt_d   = CNT_ONE;
          state_d = ST_MC_BUSY;
        end
      end
      ST_LOAD_STALL: begin
        if (redirect || (cnt_q <= CNT_ONE)) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_MC_BUSY: begin
        if (redirect || mc_done) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (wd_fire) begin
          cnt_d     = '0;
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // ------------------------------------------------------------------ outputs
  always_comb begin
    FETCH_stall = 1'b0;
    EXEC_stall  = 1'b0;
    EXEC_flush  = 1'b0;
    MEM_flush   = 1'b0;
    mc_kill     = 1'b0;
    if (!rst) begin
      unique case (state_q)
        ST_IDLE: begin
          if (redirect) begin
            EXEC_flush = 1'b1;
            MEM_flush  = 1'b1;
          end else if (load_use) begin
            FETCH_stall = 1'b1;
            EXEC_flush  = 1'b1;
          end else if (mc_req) begin
            FETCH_stall = 1'b1;
            EXEC_stall  = 1'b1;
            MEM_flush   = 1'b1;
          end
        end
        ST_LOAD_STALL: begin
          if (redirect) begin
            EXEC_flush = 1'b1;
            MEM_flush  = 1'b1;
          end else begin
            FETCH_stall = 1'b1;
            EXEC_flush  = 1'b1;
          end
        end
        ST_MC_BUSY: begin
          if (redirect) begin
            mc_kill    = 1'b1;
            EXEC_flush = 1'b1;
            MEM_flush  = 1'b1;
          end else if (mc_done) begin
            // Result advances this cycle: no stall, no flush.
          end else if (wd_fire) begin
            mc_kill    = 1'b1;
            EXEC_flush = 1'b1;
          end else begin
            FETCH_stall = 1'b1;
            EXEC_stall  = 1'b1;
            MEM_flush   = 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign FWD_rs1     = rst ? FWD_RF : fwd1_raw;
  assign FWD_rs2     = rst ? FWD_RF : fwd2_raw;
  assign mc_timeout  = timeout_q && !rst;
  assign dbg_state_o = rst ? 2'b00 : state_q;

`ifdef HAZARD_STATS_EN
  // --------------------------------------------------------------- statistics
  logic [STAT_W-1:0] stall_cnt_q, flush_cnt_q, mc_ops_q;
  logic              mc_entry;

  assign mc_entry = (state_q != ST_MC_BUSY) && (state_d == ST_MC_BUSY);

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      mc_ops_q    <= '0;
    end else begin
      if (FETCH_stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (redirect    && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 1'b1;
      if (mc_entry    && (mc_ops_q    != '1)) mc_ops_q    <= mc_ops_q + 1'b1;
    end
  end

  assign stat_stall_cycles = rst ? '0 : stall_cnt_q;
  assign stat_flushes      = rst ? '0 : flush_cnt_q;
  assign stat_mc_ops       = rst ? '0 : mc_ops_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed vectors for hazard_scoreboard
// (LOAD_LAT=2, MC_MAX_LAT=40). The driver sets inputs just after a rising edge
// and pushes the hand-computed expected output word; the monitor pops and
// compares on each falling edge.
// Expected word layout: {FWD_rs1, FWD_rs2, FETCH_stall, EXEC_stall,
//                        EXEC_flush, MEM_flush, mc_kill, mc_timeout, state}
module tb_hazard_scoreboard;

  localparam int REG_AW = 5;
  localparam int W      = 12;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LD   = 2'd1;
  localparam logic [1:0] S_MC   = 2'd2;

  // ------------------------------------------------------ clock / reset block
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              FETCH_valid, EXEC_valid, EXEC_mem2reg, EXEC_mc_start, mc_done;
  logic [REG_AW-1:0] FETCH_rs1, FETCH_rs2, EXEC_rs1, EXEC_rs2, EXEC_rd, MEM_rd, WB_rd;
  logic              MEM_valid, MEM_rd_reg_write, WB_rd_reg_write, BRA, JMP;
  logic [1:0]        FWD_rs1, FWD_rs2, dbg_state;
  logic              FETCH_stall, EXEC_stall, EXEC_flush, MEM_flush, mc_kill, mc_timeout;
`ifdef HAZARD_STATS_EN
  logic [31:0]       stat_stall_cycles, stat_flushes, stat_mc_ops;
`endif

  hazard_scoreboard #(.REG_AW(REG_AW), .LOAD_LAT(2), .MC_MAX_LAT(40)) dut (
    .clk              (clk),
    .rst              (rst),
    .FETCH_valid      (FETCH_valid),
    .FETCH_rs1        (FETCH_rs1),
    .FETCH_rs2        (FETCH_rs2),
    .EXEC_valid       (EXEC_valid),
    .EXEC_rs1         (EXEC_rs1),
    .EXEC_rs2         (EXEC_rs2),
    .EXEC_rd          (EXEC_rd),
    .EXEC_mem2reg     (EXEC_mem2reg),
    .EXEC_mc_start    (EXEC_mc_start),
    .mc_done          (mc_done),
    .MEM_valid        (MEM_valid),
    .MEM_rd           (MEM_rd),
    .WB_rd            (WB_rd),
    .MEM_rd_reg_write (MEM_rd_reg_write),
    .WB_rd_reg_write  (WB_rd_reg_write),
    .BRA              (BRA),
    .JMP              (JMP),
    .FWD_rs1          (FWD_rs1),
    .FWD_rs2          (FWD_rs2),
    .FETCH_stall      (FETCH_stall),
    .EXEC_stall       (EXEC_stall),
    .EXEC_flush       (EXEC_flush),
    .MEM_flush        (MEM_flush),
    .mc_kill          (mc_kill),
    .mc_timeout       (mc_timeout),
    .dbg_state_o      (dbg_state)
`ifdef HAZARD_STATS_EN
    ,
    .stat_stall_cycles(stat_stall_cycles),
    .stat_flushes     (stat_flushes),
    .stat_mc_ops      (stat_mc_ops)
`endif
  );

  // ---------------------------------------------------------------- scoreboard
  logic [W-1:0] exp_q[$];
  string        nm_q[$];
  int           n_cmp = 0;
  int           n_err = 0;
  logic         to_exp = 1'b0;

  logic [W-1:0] act;
  assign act = {FWD_rs1, FWD_rs2, FETCH_stall, EXEC_stall, EXEC_flush,
                MEM_flush, mc_kill, mc_timeout, dbg_state};

  function automatic logic [W-1:0] ev(logic [1:0] f1, logic [1:0] f2, logic fs, logic es,
                                      logic ef, logic mf, logic kill, logic to,
                                      logic [1:0] st);
    return {f1, f2, fs, es, ef, mf, kill, to, st};
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      string        nm;
      e  = exp_q.pop_front();
      nm = nm_q.pop_front();
      n_cmp++;
      if (act !== e) begin
        n_err++;
        $display("FAIL %s: got %b expected %b", nm, act, e);
      end
    end
  end

  // ------------------------------------------------------------ driver tasks
  task automatic clr_inputs();
    FETCH_valid = 0; FETCH_rs1 = '0; FETCH_rs2 = '0;
    EXEC_valid = 0; EXEC_rs1 = '0; EXEC_rs2 = '0; EXEC_rd = '0;
    EXEC_mem2reg = 0; EXEC_mc_start = 0; mc_done = 0;
    MEM_valid = 0; MEM_rd = '0; WB_rd = '0;
    MEM_rd_reg_write = 0; WB_rd_reg_write = 0; BRA = 0; JMP = 0;
  endtask

  // Inputs for this cycle are already applied; queue the expectation and advance.
  task automatic step(input string nm, input logic [W-1:0] e);
    exp_q.push_back(e);
    nm_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic load_use_vec();
    FETCH_valid = 1; EXEC_valid = 1; EXEC_mem2reg = 1; EXEC_rd = 5'd7; FETCH_rs2 = 5'd7;
  endtask

  // ----------------------------------------------------------------- stimulus
  initial begin
    clr_inputs();
    rst = 1;
    // Hazard-looking inputs during reset must all be masked.
    MEM_rd = 5'd5; MEM_rd_reg_write = 1; EXEC_rs1 = 5'd5; MEM_valid = 1; BRA = 1;
    @(posedge clk); #1;
    step("reset_outputs", ev(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, S_IDLE));
    rst = 0;
    clr_inputs();
    step("idle_quiet", ev(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, S_IDLE));

    // Forwarding selects.
    MEM_rd = 5'd5; WB_rd = 5'd5; MEM_rd_reg_write = 1; WB_rd_reg_write = 1;
    EXEC_rs1 = 5'd5; EXEC_rs2 = 5'd3;
    step("fwd_mem_wins", ev(2'b10, 2'b00, 0, 0, 0, 0, 0, 0, S_IDLE));
    MEM_rd_reg_write = 0;
    step("fwd_wb", ev(2'b01, 2'b00, 0, 0, 0, 0, 0, 0, S_IDLE));
    MEM_rd_reg_write = 1; EXEC_rs1 = '0; MEM_rd = '0; WB_rd = '0;
    step("fwd_x0", ev(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, S_IDLE));
    MEM_rd = 5'd4; WB_rd = 5'd9; EXEC_rs1 = 5'd4; EXEC_rs2 = 5'd9;
    step("fwd_split", ev(2'b10, 2'b01, 0, 0, 0, 0, 0, 0, S_IDLE));
    clr_inputs();

    // Load-use, 2-cycle stall; the flushed slot becomes a bubble.
    load_use_vec();
    step("ld_use_c0", ev(2'b00, 2'b00, 1, 0, 1, 0, 0, 0, S_IDLE));
    clr_inputs();
    step("ld_use_c1", ev(2'b00, 2'b00, 1, 0, 1, 0, 0, 0, S_LD));
    step("ld_use_c2", ev(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, S_IDLE));
    load_use_vec(); EXEC_rd = '0; FETCH_rs2 = '0;
    step("ld_use_x0", ev(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, S_IDLE));
    clr_inputs();
    mc_done = 1;
    step("mc_done_idle", ev(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, S_IDLE));
    clr_inputs();

    // Redirect outranks a load-use hazard in IDLE.
    load_use_vec(); MEM_valid = 1; BRA = 1;
    step("redir_idle", ev(2'b00, 2'b00, 0, 0, 1, 1, 0, 0, S_IDLE));
    clr_inputs();
    step("redir_idle_after", ev(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, S_IDLE));

    // Redirect during LOAD_STALL.
    load_use_vec();
    step("redir_ld_c0", ev(2'b00, 2'b00, 1, 0, 1, 0, 0, 0, S_IDLE));
    clr_inputs(); MEM_valid = 1; JMP = 1;
    step("redir_ld_c1", ev(2'b00, 2'b00, 0, 0, 1, 1, 0, 0, S_LD));
    clr_inputs();
    step("redir_ld_c2", ev(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, S_IDLE));

    // Multi-cycle op completing at cycle 33.
    EXEC_valid = 1; EXEC_mc_start = 1;
    step("mc_c0", ev(2'b00, 2'b00, 1, 1, 0, 1, 0, 0, S_IDLE));
    for (int c = 1; c <= 32; c++)
      step($sformatf("mc_c%0d", c), ev(2'b00, 2'b00, 1, 1, 0, 1, 0, 0, S_MC));
    mc_done = 1;
    step("mc_c33_done", ev(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, S_MC));
    clr_inputs();
    step("mc_c34", ev(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, S_IDLE));

    // Redirect at cycle 5 of MC_BUSY, together with mc_done.
    EXEC_valid = 1; EXEC_mc_start = 1;
    step("mck_c0", ev(2'b00, 2'b00, 1, 1, 0, 1, 0, 0, S_IDLE));
    for (int c = 1; c <= 4; c++)
      step($sformatf("mck_c%0d", c), ev(2'b00, 2'b00, 1, 1, 0, 1, 0, 0, S_MC));
    MEM_valid = 1; BRA = 1; mc_done = 1;
    step("mck_c5_kill", ev(2'b00, 2'b00, 0, 0, 1, 1, 1, 0, S_MC));
    clr_inputs();
    step("mck_c6", ev(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, S_IDLE));

    // Watchdog: no mc_done, fires at cycle 40.
    EXEC_valid = 1; EXEC_mc_start = 1;
    step("wd_c0", ev(2'b00, 2'b00, 1, 1, 0, 1, 0, 0, S_IDLE));
    clr_inputs();
    for (int c = 1; c <= 39; c++)
      step($sformatf("wd_c%0d", c), ev(2'b00, 2'b00, 1, 1, 0, 1, 0, 0, S_MC));
    step("wd_c40_fire", ev(2'b00, 2'b00, 0, 0, 1, 0, 1, 0, S_MC));
    to_exp = 1'b1;
    step("wd_c41_sticky", ev(2'b00, 2'b00, 0, 0, 0, 0, 0, to_exp, S_IDLE));
    WB_rd = 5'd3; WB_rd_reg_write = 1; EXEC_rs2 = 5'd3;
    step("wd_traffic_fwd", ev(2'b00, 2'b01, 0, 0, 0, 0, 0, to_exp, S_IDLE));
    clr_inputs();

    // Reset in the middle of LOAD_STALL.
    load_use_vec();
    step("rst_ld_c0", ev(2'b00, 2'b00, 1, 0, 1, 0, 0, to_exp, S_IDLE));
    clr_inputs();
    rst = 1;
    step("rst_ld_c1", ev(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, S_IDLE));
    rst = 0;
    to_exp = 1'b0;
    step("rst_after", ev(2'b00, 2'b00, 0, 0, 0, 0, 0, to_exp, S_IDLE));
`ifdef HAZARD_STATS_EN
    n_cmp++;
    if ({stat_stall_cycles, stat_flushes, stat_mc_ops} !== '0) begin
      n_err++;
      $display("FAIL stats_cleared: got %0d/%0d/%0d expected 0/0/0",
               stat_stall_cycles, stat_flushes, stat_mc_ops);
    end
`endif

    // Drain and report.
    @(posedge clk); #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the 5-stage pipeline hazard unit.
- Keeps the combinational EXEC operand-forwarding selects and the branch/jump flush.
- Adds sequenced stalls:
  - a load-use stall of configurable length (LOAD_LAT cycles);
  - a multi-cycle execute-unit interlock (divider/multiplier) with a timeout watchdog.
- Sits beside the pipeline registers; drives their stall/flush enables and the EXEC operand muxes.

Parameters:
- REG_AW, 5, register address width; x0 is never a hazard source.
- LOAD_LAT, 1, stall cycles inserted on a load-use hazard (>=1).
- MC_MAX_LAT, 40, max cycles in MC_BUSY before the watchdog fires (>=2).
- STAT_W, 32, statistics counter width (only with HAZARD_STATS_EN).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- FETCH_valid  in  1  decode-stage instruction valid
- FETCH_rs1, FETCH_rs2  in  REG_AW  decode-stage sources
- EXEC_valid  in  1  EXEC-stage instruction valid
- EXEC_rs1, EXEC_rs2, EXEC_rd  in  REG_AW  EXEC sources/destination
- EXEC_mem2reg  in  1  EXEC instruction is a load
- EXEC_mc_start  in  1  EXEC instruction uses the multi-cycle unit
- mc_done  in  1  multi-cycle result valid (1-cycle pulse)
- MEM_valid  in  1  MEM-stage valid
- MEM_rd, WB_rd  in  REG_AW  destinations
- MEM_rd_reg_write, WB_rd_reg_write  in  1  write enables
- BRA, JMP  in  1  taken branch / jump resolved in MEM
- FWD_rs1, FWD_rs2  out  2  00 regfile, 01 WB, 10 MEM
- FETCH_stall  out  1  hold IF/ID register
- EXEC_stall  out  1  hold ID/EX register
- EXEC_flush  out  1  bubble into ID/EX at next edge
- MEM_flush  out  1  bubble into EX/MEM at next edge
- mc_kill  out  1  abort the multi-cycle unit
- mc_timeout  out  1  sticky watchdog error

Behaviour:
Reset:
- rst=1 at an edge: state=IDLE, counters=0, mc_timeout=0.
- While rst=1, all outputs are forced to 0.

Forwarding (combinational, every state):
- FWD_rsN=10 if MEM_rd_reg_write & MEM_rd!=0 & MEM_rd==EXEC_rsN.
- Else 01 if the same condition holds for WB.
- Else 00.

FSM states: IDLE, LOAD_STALL, MC_BUSY.
- Redirect = MEM_valid & (BRA|JMP).

IDLE:
- Redirect: EXEC_flush=1, MEM_flush=1, FETCH_stall=0; stay IDLE. Redirect has priority over all hazards.
- Else load-use: FETCH_valid & EXEC_valid & EXEC_mem2reg & EXEC_rd!=0 & (EXEC_rd==FETCH_rs1 | EXEC_rd==FETCH_rs2).
  - Outputs: FETCH_stall=1, EXEC_flush=1.
  - If LOAD_LAT>1: cnt<=LOAD_LAT-1, go LOAD_STALL.
- Else EXEC_valid & EXEC_mc_start:
  - Outputs: FETCH_stall=1, EXEC_stall=1, MEM_flush=1.
  - cnt<=1, go MC_BUSY.
- mc_done is ignored in IDLE.

LOAD_STALL:
- Outputs: FETCH_stall=1, EXEC_flush=1.
- cnt decrements; return to IDLE after the cycle with cnt==1. Total stall = LOAD_LAT cycles.
- Redirect: stalls drop, EXEC_flush=1, MEM_flush=1, go IDLE.

MC_BUSY:
- While !mc_done: FETCH_stall=1, EXEC_stall=1, MEM_flush=1; cnt increments.
- mc_done: all stalls 0 that cycle (result advances), go IDLE.
- Redirect: mc_kill=1 for one cycle, EXEC_flush=1, MEM_flush=1, go IDLE. Redirect outranks a simultaneous mc_done.
- Watchdog: cnt==MC_MAX_LAT & !mc_done → mc_timeout<=1 (sticky until rst), mc_kill=1, EXEC_flush=1, go IDLE.

General:
- Counter width is $clog2(MC_MAX_LAT+1).
- Counters saturate and never wrap.
- Outputs are Mealy (state plus current inputs); no added latency.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- Defined: adds outputs stat_stall_cycles, stat_flushes, stat_mc_ops (each STAT_W).
  - stat_stall_cycles counts cycles with FETCH_stall=1.
  - stat_flushes counts redirects.
  - stat_mc_ops counts MC_BUSY entries.
  - All saturate at all-ones and clear on rst.
- Undefined: ports and registers are absent; all other behaviour is identical.

Decomposition:
- Shared package hazard_pkg:
  - state enum (IDLE/LOAD_STALL/MC_BUSY);
  - FWD encodings FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
- One sub-module, hazard_fwd: purely combinational forwarding selects, reused for rs1/rs2.

Test Plan:
1. Forwarding: MEM_rd=WB_rd=5, both write enables=1, EXEC_rs1=5 → FWD_rs1=10. Then MEM_rd_reg_write=0 → 01. Then EXEC_rs1=0 with MEM_rd=WB_rd=0 → 00.
2. Load-use, LOAD_LAT=2: EXEC_mem2reg=1, EXEC_rd=7, FETCH_rs2=7, both valids=1 → FETCH_stall=1 and EXEC_flush=1 for exactly 2 cycles, then 0.
3. Multi-cycle: EXEC_mc_start=1 at cycle 0, mc_done at cycle 33 → FETCH_stall/EXEC_stall/MEM_flush=1 on cycles 0–32, 0 on cycle 33, state IDLE.
4. Redirect during MC_BUSY: BRA=1 & MEM_valid=1 at cycle 5 → mc_kill=1 that cycle, EXEC_flush=MEM_flush=1, stalls 0, IDLE next cycle.
5. Watchdog, MC_MAX_LAT=8: no mc_done → mc_timeout=1 from cycle 9 onward, held through later traffic until rst=1.
6. rst=1 mid-LOAD_STALL → outputs 0 immediately; with HAZARD_STATS_EN, all stat counters read 0 after the edge.
